// File: rtl/les_io_pkg.sv
// LES I/O front end: shared states and command codes.
// Imported by the controller and its helpers.
package les_io_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPT,
    S_SEND
  } state_t;

  localparam logic [7:0] CMD_ENC = 8'h70;
  localparam logic [7:0] CMD_CLR = 8'h72;
  localparam logic [7:0] RSP_UNK = 8'h3F;
  localparam int NUM_BYTES = 4;

endpackage

// File: rtl/les_io_timer.sv
// Clear/enable cycle counter with a terminal flag.
// Saturates at TIMEOUT so done stays high until cleared.
module les_io_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign done = (cnt == TW'(TIMEOUT));

endmodule

// File: rtl/les_io_ctrl.sv
// Byte-stream command front end for the LES core.
// Loads plaintext, starts the core, streams the cipher back.
module les_io_ctrl
  import les_io_pkg::*;
#(
  parameter int TIMEOUT    = 1000,
  parameter int TRIG_EXTRA = 0
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] les_plaintext,
  output logic        les_start,
  input  logic        les_busy,
  input  logic [31:0] les_cipher,
  output logic        les_clr,
  output logic        trigger,
  output logic        err
);

  state_t state, nstate;

  logic       rx_acc, tx_hs;
  logic       tmr_clr, tmr_en, tmr_done;
  logic       err_d, clr_cmd, cap_go;
  logic       load_wr, rsp_go;
  logic [7:0] rsp_byte;

  logic [1:0]  byte_cnt;
  logic [2:0]  tx_left;
  logic [31:0] tx_sr;
  logic [3:0]  ext_q, ext_d;

  assign rx_acc  = rx_valid && rx_ready;
  assign tx_hs   = tx_valid && tx_ready;
  assign tx_data = tx_sr[7:0];

  les_io_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .clr_n(clr_n),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .done (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate   = state;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    err_d    = 1'b0;
    clr_cmd  = 1'b0;
    cap_go   = 1'b0;
    load_wr  = 1'b0;
    rsp_go   = 1'b0;
    rsp_byte = RSP_UNK;
    unique case (state)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (rx_acc) begin
          unique case (1'b1)
            (rx_data == CMD_ENC): begin
              nstate = S_LOAD;
            end
            (rx_data == CMD_CLR): begin
              clr_cmd  = 1'b1;
              rsp_go   = 1'b1;
              rsp_byte = CMD_CLR;
              nstate   = S_SEND;
            end
            default: begin
              rsp_go = 1'b1;
              nstate = S_SEND;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (rx_acc) begin
          load_wr = 1'b1;
          tmr_clr = 1'b1;
          if (byte_cnt == 2'(NUM_BYTES - 1)) begin
            nstate = S_START;
          end
        end else if (tmr_done) begin
          err_d  = 1'b1;
          nstate = S_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_START: begin
        tmr_clr = 1'b1;
        nstate  = S_WAIT;
      end
      S_WAIT: begin
        if (!les_busy) begin
          cap_go = 1'b1;
          nstate = S_CAPT;
        end else if (tmr_done) begin
          err_d  = 1'b1;
          nstate = S_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_CAPT: begin
        nstate = S_SEND;
      end
      S_SEND: begin
        if (tx_hs && tx_left == 3'd1) begin
          nstate = S_IDLE;
        end
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  // Trigger tail countdown, loaded when busy falls.
  always_comb begin
    ext_d = ext_q;
    if (cap_go) begin
      ext_d = 4'(TRIG_EXTRA);
    end else if (ext_q != 4'd0) begin
      ext_d = ext_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rx_ready      <= 1'b0;
      tx_valid      <= 1'b0;
      les_start     <= 1'b0;
      trigger       <= 1'b0;
      err           <= 1'b0;
      les_clr       <= 1'b1;
      les_plaintext <= '0;
      byte_cnt      <= '0;
      tx_left       <= '0;
      tx_sr         <= '0;
      ext_q         <= '0;
    end else begin
      rx_ready  <= (nstate == S_IDLE) || (nstate == S_LOAD);
      tx_valid  <= (nstate == S_SEND);
      les_start <= (nstate == S_START);
      trigger   <= (nstate == S_START) || (nstate == S_WAIT) ||
                   (ext_d != 4'd0);
      err       <= err_d;
      les_clr   <= clr_cmd;
      ext_q     <= ext_d;
      if (state == S_IDLE) begin
        byte_cnt <= '0;
      end else if (load_wr) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (load_wr) begin
        les_plaintext[{byte_cnt, 3'b000} +: 8] <= rx_data;
      end
      if (rsp_go) begin
        tx_sr   <= {24'h0, rsp_byte};
        tx_left <= 3'd1;
      end else if (state == S_CAPT) begin
        tx_sr   <= les_cipher;
        tx_left <= 3'(NUM_BYTES);
      end else if (state == S_SEND && tx_hs) begin
        tx_sr   <= {8'h00, tx_sr[31:8]};
        tx_left <= tx_left - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_les_io_ctrl.sv
// Scoreboard bench for les_io_ctrl with a simple LES core model.
// Core busy window is 4 cycles; cipher is plaintext XOR a fixed key.
module tb_les_io_ctrl;

  localparam int TO = 16;
  localparam int TX = 2;
  localparam logic [31:0] KEY = 32'hA5B1C1D5;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] les_plaintext;
  logic        les_start;
  logic        les_busy;
  logic [31:0] les_cipher;
  logic        les_clr;
  logic        trigger;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  bit bp = 0;
  bit hang = 0;
  bit hang_act = 0;
  bit rst_edge = 0;
  int bcnt = 0;
  int starts = 0;
  int clrs = 0;
  int trig_hi = 0;
  int first_exp = -1;

  always #5 clk = ~clk;

  les_io_ctrl #(
    .TIMEOUT(TO),
    .TRIG_EXTRA(TX)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .les_plaintext(les_plaintext),
    .les_start    (les_start),
    .les_busy     (les_busy),
    .les_cipher   (les_cipher),
    .les_clr      (les_clr),
    .trigger      (trigger),
    .err          (err)
  );

  // Core model: busy high in the start cycle and 3 more.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !clr_n;
    if (!clr_n || les_clr) begin
      bcnt     <= 0;
      hang_act <= 1'b0;
    end else if (les_start) begin
      bcnt     <= 3;
      hang_act <= hang;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  assign les_busy   = les_start | (bcnt != 0) | hang_act;
  assign les_cipher = les_plaintext ^ KEY;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor and tx_ready driver.
  bit st = 0;
  bit pst = 0;
  bit perr = 0;
  int stall = 0;
  logic [7:0] st_data = 8'h00;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (les_start) begin
        starts++;
        chk("start_w", 32'(pst), 0);
      end
      pst = les_start;
      if (err) chk("err_w", 32'(perr), 0);
      perr = err;
      if (les_clr) clrs++;
      if (trigger) trig_hi++;
      if (les_busy && !hang_act) chk("trig_busy", 32'(trigger), 1);
      if (st && !rst_edge) begin
        chk("hold_v", 32'(tx_valid), 1);
        chk("hold_d", 32'(tx_data), 32'(st_data));
      end
      if (tx_valid) begin
        chk("rx_blk", 32'(rx_ready), 0);
        if (first_exp >= 0) begin
          chk("lat", cyc, first_exp);
          first_exp = -1;
        end
      end
      tx_ready = 1'b1;
      if (bp && tx_valid) begin
        if (stall < 3) begin
          tx_ready = 1'b0;
          stall++;
        end else begin
          stall = 0;
        end
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_extra", 32'(tx_data), 32'hFFFF_FFFF);
        else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      st = tx_valid && !tx_ready;
      st_data = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!ok && n < 200) begin
      ok = rx_ready;
      @(negedge clk);
      n++;
    end
    rx_valid = 1'b0;
    acc = cyc;
    if (!ok) chk("rx_to", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic send_enc(input logic [31:0] pt, output int acc);
    send_byte(8'h70, acc);
    for (int k = 0; k < 4; k++) send_byte(pt[8*k +: 8], acc);
  endtask

  task automatic do_enc(input logic [31:0] pt);
    logic [31:0] ct;
    int s0, t0, acc;
    ct = pt ^ KEY;
    for (int k = 0; k < 4; k++) exp_q.push_back(ct[8*k +: 8]);
    s0 = starts;
    t0 = trig_hi;
    send_enc(pt, acc);
    chk("pt", les_plaintext, pt);
    first_exp = acc + 6;
    drain();
    chk("start_n", starts - s0, 1);
    chk("trig_n", trig_hi - t0, 5 + TX);
    chk("trig_end", 32'(trigger), 0);
  endtask

  task automatic check_reset_vals();
    chk("r_rx_ready", 32'(rx_ready), 0);
    chk("r_tx_valid", 32'(tx_valid), 0);
    chk("r_tx_data", 32'(tx_data), 0);
    chk("r_pt", les_plaintext, 0);
    chk("r_start", 32'(les_start), 0);
    chk("r_trigger", 32'(trigger), 0);
    chk("r_err", 32'(err), 0);
    chk("r_les_clr", 32'(les_clr), 1);
  endtask

  task automatic pulse_reset();
    #1;
    clr_n = 1'b0;
    exp_q.delete();
    first_exp = -1;
    @(negedge clk);
    check_reset_vals();
    #1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(rx_ready), 1);
    chk("post_rst_clr", 32'(les_clr), 0);
  endtask

  initial begin
    int acc, s0, c0, n;
    repeat (2) @(negedge clk);
    check_reset_vals();
    #1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("init_rdy", 32'(rx_ready), 1);
    chk("init_clr", 32'(les_clr), 0);

    do_enc(32'h04030201);

    bp = 1'b1;
    do_enc(32'h0D0C0B0A);
    bp = 1'b0;

    c0 = clrs;
    s0 = starts;
    exp_q.push_back(8'h72);
    send_byte(8'h72, acc);
    drain();
    chk("clr_pulse", clrs - c0, 1);
    exp_q.push_back(8'h3F);
    send_byte(8'h55, acc);
    drain();
    chk("cmd_nostart", starts - s0, 0);

    // Stalled payload: error after TO idle cycles.
    s0 = starts;
    send_byte(8'h70, acc);
    send_byte(8'h11, acc);
    n = 0;
    while (!err && n < TO + 10) begin
      @(negedge clk);
      n++;
    end
    chk("lto_err", 32'(err), 1);
    chk("lto_cyc", 32'(cyc >= acc + TO && cyc <= acc + TO + 2), 1);
    chk("lto_rdy", 32'(rx_ready), 1);
    chk("lto_pt", 32'(les_plaintext[7:0]), 32'h11);
    @(negedge clk);
    chk("lto_err_off", 32'(err), 0);
    chk("lto_nostart", starts - s0, 0);
    do_enc(32'h44332211);

    // Core never drops busy.
    hang = 1'b1;
    s0 = starts;
    send_enc(32'h87654321, acc);
    repeat (2) @(negedge clk);
    chk("bto_trig_on", 32'(trigger), 1);
    n = 0;
    while (!err && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    chk("bto_err", 32'(err), 1);
    chk("bto_cyc", 32'(cyc >= acc + TO && cyc <= acc + TO + 3), 1);
    chk("bto_trig_off", 32'(trigger), 0);
    chk("bto_txv", 32'(tx_valid), 0);
    chk("bto_rdy", 32'(rx_ready), 1);
    chk("bto_start", starts - s0, 1);
    hang = 1'b0;
    exp_q.push_back(8'h72);
    send_byte(8'h72, acc);
    drain();

    // Reset while waiting on the core.
    send_enc(32'h55667788, acc);
    repeat (2) @(negedge clk);
    pulse_reset();
    do_enc(32'h99AABBCC);

    // Reset in the middle of a stalled send.
    bp = 1'b1;
    begin
      logic [31:0] ct;
      ct = 32'h13579BDF ^ KEY;
      for (int k = 0; k < 4; k++) exp_q.push_back(ct[8*k +: 8]);
    end
    send_enc(32'h13579BDF, acc);
    n = 0;
    while (exp_q.size() > 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_send", exp_q.size(), 2);
    pulse_reset();
    bp = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_txv", 32'(tx_valid), 0);
    do_enc(32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
